// File: rtl/aes_round_tail_if.sv
// rtl/aes_round_tail_if.sv - accept/result handshake bundle for the AES round tail
interface aes_round_tail_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_round_key;
  logic         in_last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, in_round_key, in_last_round, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_round_key, in_last_round, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/aes_round_tail.sv
// rtl/aes_round_tail.sv - AES round tail: ShiftRows, column-serial MixColumns, AddRoundKey
module aes_round_tail #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst_n,
  aes_round_tail_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  state_t       state, state_nx;
  logic [2:0]   col, col_nx, col_sum;
  logic [127:0] shifted, shifted_nx;
  logic [127:0] key, key_nx;
  logic [127:0] result, result_nx;
  logic [127:0] mixed;
  logic [127:0] in_shifted;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word holds bytes r0..r3 from MSB to LSB
  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  assign in_shifted = shift_rows(bus.in_state);
  assign col_sum    = col + 3'(COLS_PER_CYCLE);

  // Only COLS_PER_CYCLE mix units; the column slice is selected by the counter
  always_comb begin
    mixed = result;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      mixed[127-32*(int'(col)+j) -: 32] = mix_col(shifted[127-32*(int'(col)+j) -: 32])
                                          ^ key[127-32*(int'(col)+j) -: 32];
    end
  end

  always_comb begin
    state_nx   = state;
    col_nx     = col;
    shifted_nx = shifted;
    key_nx     = key;
    result_nx  = result;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          shifted_nx = in_shifted;
          key_nx     = bus.in_round_key;
          col_nx     = 3'd0;
          if (bus.in_last_round) begin
            result_nx = in_shifted ^ bus.in_round_key;
            state_nx  = DONE;
          end else begin
            state_nx  = MIX;
          end
        end
      end
      MIX: begin
        result_nx = mixed;
        if (col_sum[2]) begin
          col_nx   = 3'd0;
          state_nx = DONE;
        end else begin
          col_nx   = col_sum;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col     <= 3'd0;
      shifted <= '0;
      key     <= '0;
      result  <= '0;
    end else begin
      state   <= state_nx;
      col     <= col_nx;
      shifted <= shifted_nx;
      key     <= key_nx;
      result  <= result_nx;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_state = result;

endmodule
